// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared arbiter state type, stat width and round-robin pick helper
package fifo_arb_pkg;

    localparam int STAT_W = 16;
    localparam int RR_MAX = 16;
    localparam int RR_IW  = 4;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // First set bit of valid[n-1:0] searching upward from last+1, wrapping at n.
    // The loop runs downward so the nearest candidate is the one written last.
    function automatic logic [RR_IW-1:0] rr_pick(
        input logic [RR_MAX-1:0] valid,
        input int                last,
        input int                n
    );
        int idx;
        rr_pick = RR_IW'(last);
        for (int k = RR_MAX; k >= 1; k--) begin
            idx = last + k;
            if (idx >= n) begin
                idx = idx - n;
            end
            if ((k <= n) && valid[idx[3:0]]) begin
                rr_pick = RR_IW'(idx);
            end
        end
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// rtl/fifo_rr_pick.sv - combinational round-robin priority encoder (valid, last -> idx, any)
module fifo_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_valid,
    input  logic [IW-1:0] i_last,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [RR_MAX-1:0] w_valid_ext;
    logic [RR_IW-1:0]  w_pick;

    always_comb begin
        w_valid_ext         = '0;
        w_valid_ext[N-1:0]  = i_valid;
    end

    assign w_pick = rr_pick(w_valid_ext, int'(i_last), N);
    assign o_idx  = w_pick[IW-1:0];
    assign o_any  = |i_valid;

endmodule

// File: rtl/fifo_wr_arb.sv
// rtl/fifo_wr_arb.sv - round-robin burst-bounded arbiter for the FIFO write port; FIFO_WR_ARB_STATS_EN adds counters
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter  int DSIZE     = 8,
    parameter  int NREQ      = 4,
    parameter  int BURST_LEN = 4,
    localparam int GW        = $clog2(NREQ),
    localparam int BW        = $clog2(BURST_LEN + 1)
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*DSIZE-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic [GW-1:0]         gnt_id,
    output logic                  busy
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [NREQ*STAT_W-1:0] stat_words,
    output logic [STAT_W-1:0]      stat_full_stall
`endif
);

    arb_state_t    r_state;
    logic [GW-1:0] r_gnt_id;
    logic [GW-1:0] r_last;
    logic [BW-1:0] r_beat;

    logic [GW-1:0] w_pick_idx;
    logic          w_pick_any;
    logic          w_gnt_valid;
    logic          w_xfer;
    logic          w_burst_done;
    logic          w_release;

    fifo_rr_pick #(
        .N (NREQ)
    ) u_pick (
        .i_valid (req_valid),
        .i_last  (r_last),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    assign w_gnt_valid  = req_valid[r_gnt_id];
    assign busy         = (r_state == ARB_GRANT);
    // wrst gating keeps the write port quiet in the reset cycle itself
    assign winc         = busy && w_gnt_valid && !wfull && !wrst;
    assign w_xfer       = winc;
    assign w_burst_done = (r_beat == BW'(BURST_LEN - 1));
    assign w_release    = (w_xfer && w_burst_done) || !w_gnt_valid;
    assign wdata        = req_data[r_gnt_id*DSIZE +: DSIZE];
    assign gnt_id       = r_gnt_id;

    always_comb begin
        req_ready = '0;
        if (busy && !wfull && !wrst) begin
            req_ready[r_gnt_id] = 1'b1;
        end
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_state  <= ARB_IDLE;
            r_gnt_id <= '0;
            r_last   <= GW'(NREQ - 1);
            r_beat   <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_pick_any) begin
                        r_gnt_id <= w_pick_idx;
                        r_state  <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (w_release) begin
                        r_state <= ARB_IDLE;
                        r_last  <= r_gnt_id;
                        r_beat  <= '0;
                    end else if (w_xfer) begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [STAT_W-1:0] r_words [NREQ];
    logic [STAT_W-1:0] r_stall;

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            for (int i = 0; i < NREQ; i++) begin
                r_words[i] <= '0;
            end
            r_stall <= '0;
        end else begin
            if (w_xfer && (r_words[r_gnt_id] != '1)) begin
                r_words[r_gnt_id] <= r_words[r_gnt_id] + 1'b1;
            end
            if (busy && w_gnt_valid && wfull && (r_stall != '1)) begin
                r_stall <= r_stall + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_stat
        assign stat_words[g*STAT_W +: STAT_W] = r_words[g];
    end
    assign stat_full_stall = r_stall;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb/tb_fifo_wr_arb.sv - self-checking bench for fifo_wr_arb against a behavioural arbitration model
module tb_fifo_wr_arb;

    localparam int DSIZE     = 8;
    localparam int NREQ      = 4;
    localparam int BURST_LEN = 4;
    localparam int GW        = 2;

    logic                  wclk = 1'b0;
    logic                  wrst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  wfull;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic [GW-1:0]         gnt_id;
    logic                  busy;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [NREQ*16-1:0]    stat_words;
    logic [15:0]           stat_full_stall;
`endif

    fifo_wr_arb #(
        .DSIZE     (DSIZE),
        .NREQ      (NREQ),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .wclk            (wclk),
        .wrst            (wrst),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .wfull           (wfull),
        .winc            (winc),
        .wdata           (wdata),
        .gnt_id          (gnt_id),
`ifdef FIFO_WR_ARB_STATS_EN
        .stat_words      (stat_words),
        .stat_full_stall (stat_full_stall),
`endif
        .busy            (busy)
    );

    always #5 wclk = ~wclk;

    int errors = 0;
    int checks = 0;

    logic [DSIZE-1:0]      q [NREQ][$];
    logic [NREQ-1:0]       en;
    logic [NREQ-1:0]       acc;
    logic [NREQ-1:0]       prev_hold;
    logic [NREQ*DSIZE-1:0] prev_data;

    bit m_busy;
    int m_gnt, m_last, m_beat, m_stall;
    int m_words [NREQ];

    int log_id [$];
    int log_len [$];
    bit prev_busy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int next_owner(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic m_reset();
        m_busy = 0; m_gnt = 0; m_last = NREQ - 1; m_beat = 0; m_stall = 0;
        for (int i = 0; i < NREQ; i++) m_words[i] = 0;
        prev_busy = 0;
        log_id.delete();
        log_len.delete();
    endtask

    task automatic load(input int r, input int n);
        for (int k = 0; k < n; k++) q[r].push_back(DSIZE'($urandom));
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) void'(q[i].pop_front());
            if (!(req_valid[i] && !acc[i])) req_valid[i] = (q[i].size() > 0) && en[i];
            req_data[i*DSIZE +: DSIZE] = (q[i].size() > 0) ? q[i][0] : '0;
        end
        acc = '0;
    endtask

    task automatic sample();
        logic            exp_winc;
        logic [NREQ-1:0] exp_rdy;
        int              p;
        for (int i = 0; i < NREQ; i++) begin
            if (prev_hold[i]) begin
                assert (req_valid[i] && (req_data[i*DSIZE +: DSIZE] === prev_data[i*DSIZE +: DSIZE]))
                else $error("requester %0d broke the hold-until-ready rule", i);
            end
        end
        if (wrst) begin
            chk("rst_busy", busy, 0);
            chk("rst_gnt", gnt_id, 0);
            chk("rst_winc", winc, 0);
            chk("rst_ready", req_ready, 0);
            acc = '0;
        end else begin
            exp_winc = m_busy && req_valid[m_gnt] && !wfull;
            exp_rdy  = '0;
            if (m_busy && !wfull) exp_rdy[m_gnt] = 1'b1;
            chk("busy", busy, m_busy);
            chk("gnt_id", gnt_id, m_gnt);
            chk("winc", winc, exp_winc);
            chk("req_ready", req_ready, exp_rdy);
            if (m_busy) chk("wdata", wdata, req_data[m_gnt*DSIZE +: DSIZE]);
            acc = req_valid & req_ready;
            if (busy && !prev_busy) begin
                log_id.push_back(int'(gnt_id));
                log_len.push_back(0);
            end
            if (winc && log_len.size() > 0) log_len[log_len.size()-1] += 1;
            prev_busy = busy;
            if (!m_busy) begin
                p = next_owner(req_valid, m_last);
                if (p >= 0) begin
                    m_gnt  = p;
                    m_busy = 1;
                end
            end else begin
                if (req_valid[m_gnt] && wfull && m_stall < 16'hFFFF) m_stall++;
                if (exp_winc) begin
                    m_beat++;
                    if (m_words[m_gnt] < 16'hFFFF) m_words[m_gnt]++;
                end
                if ((exp_winc && m_beat == BURST_LEN) || !req_valid[m_gnt]) begin
                    m_last = m_gnt;
                    m_beat = 0;
                    m_busy = 0;
                end
            end
        end
        prev_hold = req_valid & ~acc;
        prev_data = req_data;
    endtask

    task automatic cycle();
        @(negedge wclk);
        sample();
        @(posedge wclk);
        #1;
        drive();
    endtask

`ifdef FIFO_WR_ARB_STATS_EN
    task automatic check_stats();
        for (int i = 0; i < NREQ; i++)
            chk($sformatf("stat_words%0d", i), stat_words[i*16 +: 16], m_words[i]);
        chk("stat_full_stall", stat_full_stall, m_stall);
    endtask
`endif

    task automatic do_reset(input bit with_stats);
`ifdef FIFO_WR_ARB_STATS_EN
        if (with_stats) check_stats();
`endif
        wrst = 1'b1;
        m_reset();
        #1;
        chk("rst_now_busy", busy, 0);
        chk("rst_now_winc", winc, 0);
        chk("rst_now_gnt", gnt_id, 0);
        chk("rst_now_ready", req_ready, 0);
        repeat (2) cycle();
        wrst = 1'b0;
    endtask

    function automatic bit pending();
        bit any = m_busy;
        for (int i = 0; i < NREQ; i++) if (q[i].size() > 0) any = 1;
        return any;
    endfunction

    task automatic run_drain(input int budget, input string tag);
        int n = 0;
        while (pending() && n < budget) begin
            cycle();
            n++;
        end
        chk({tag, "_drain_in_budget"}, n < budget, 1);
        repeat (2) cycle();
    endtask

    task automatic wait_beats(input int beats, input int budget, input string tag);
        int n = 0;
        while (!(m_busy && m_beat == beats) && n < budget) begin
            cycle();
            n++;
        end
        chk({tag, "_beat_reached"}, n < budget, 1);
    endtask

    task automatic check_log(input string tag, input int ids[$], input int lens[$]);
        chk({tag, "_grants"}, log_id.size(), ids.size());
        for (int i = 0; i < ids.size() && i < log_id.size(); i++) begin
            chk($sformatf("%s_id%0d", tag, i), log_id[i], ids[i]);
            chk($sformatf("%s_len%0d", tag, i), log_len[i], lens[i]);
        end
    endtask

    initial begin
        req_valid = '0;
        req_data  = '0;
        wfull     = 1'b0;
        en        = '0;
        acc       = '0;
        prev_hold = '0;
        prev_data = '0;
        do_reset(0);

        // single requester, 10 words: bursts of 4,4,2 with bubbles
        en = 4'b0001;
        load(0, 10);
        run_drain(80, "single");
        check_log("single", '{0, 0, 0}, '{4, 4, 2});

        // all requesters with 8 words: strict rotation, 4 beats per grant
        do_reset(1);
        en = 4'b1111;
        for (int i = 0; i < NREQ; i++) load(i, 8);
        run_drain(120, "rotate");
        check_log("rotate", '{0, 1, 2, 3, 0, 1, 2, 3}, '{4, 4, 4, 4, 4, 4, 4, 4});

        // wfull held for 5 cycles after 2 beats of requester 2
        do_reset(1);
        en = 4'b0100;
        load(2, 4);
        wait_beats(2, 20, "full");
        wfull = 1'b1;
        repeat (5) cycle();
        wfull = 1'b0;
`ifdef FIFO_WR_ARB_STATS_EN
        chk("stall_is_5", stat_full_stall, 5);
`endif
        run_drain(40, "full");
        check_log("full", '{2}, '{4});

        // requester 1 leaves after one beat, requester 2 takes over
        do_reset(1);
        en = 4'b0110;
        load(1, 1);
        load(2, 3);
        run_drain(40, "drop");
        check_log("drop", '{1, 2}, '{1, 3});

        // reset during beat 3, then requester 0 first again
        en = 4'b0011;
        load(0, 8);
        wait_beats(2, 30, "midrst");
        chk("midrst_winc_before", winc, 1);
        load(1, 2);
        do_reset(1);
        run_drain(60, "midrst");
        check_log("midrst", '{0, 1, 0}, '{4, 2, 2});

        // randomized traffic with random wfull and requester enables
        en = '1;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(7) == 0) en = NREQ'($urandom);
            wfull = ($urandom_range(3) == 0);
            for (int i = 0; i < NREQ; i++)
                if (q[i].size() < 3 && $urandom_range(3) == 0) load(i, $urandom_range(1, 6));
            cycle();
        end
        wfull = 1'b0;
        en    = '1;
        run_drain(400, "random");
`ifdef FIFO_WR_ARB_STATS_EN
        check_stats();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
